protocol_fsm: RTL and testbench
===============================

PROTOCOL_FSM -- requirements
Module: protocol_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the number of cycles to wait for a response before declaring a timeout.
REQ-002 SHALL have parameter MAX_TRIES, default 8, meaning the number of attempts allowed before the transaction fails.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port rst_b, input, 1 bit, reset: asynchronous, active-low.
REQ-005 SHALL have port token_pkt, input, 19 bits: {PID[7:0], ADDR[6:0], ENDP[3:0]}.
REQ-006 SHALL have port data_pkt, input, 72 bits: {PID[7:0], payload[63:0]}, used for OUT transactions only.
REQ-007 SHALL have port data_avail, input, 1 bit: the upstream rw stage requests a transaction.
REQ-008 SHALL have port ptcl_ready, output, 1 bit: the block is idle and can accept a request.
REQ-009 SHALL have port ptcl_done, output, 1 bit: one-cycle pulse when a transaction ends.
REQ-010 SHALL have port ptcl_success, output, 1 bit: the result, valid only while ptcl_done is high.
REQ-011 SHALL have port rx_data, output, 64 bits: the payload from the last successful IN transaction.
REQ-012 SHALL have port tx_start, output, 1 bit: one-cycle pulse to the bit encoder to begin sending.
REQ-013 SHALL have port tx_kind, output, 2 bits: 00 token, 01 data, 10 handshake.
REQ-014 SHALL have port tx_pkt, output, 72 bits: the packet to send; a token sits in [18:0] and a handshake PID in [7:0], with unused bits 0.
REQ-015 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the encoder when the packet and EOP are fully sent.
REQ-016 SHALL have port rx_valid, input, 1 bit: one-cycle pulse when a received packet is decoded.
REQ-017 SHALL have port rx_pid, input, 8 bits: the PID of the received packet.
REQ-018 SHALL have port rx_payload, input, 64 bits: the payload of the received packet.
REQ-019 SHALL have port rx_crc_ok, input, 1 bit: the received CRC check passed.

Function
REQ-020 SHALL decode PIDs as constants: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, ACK 8'hD2, NAK 8'h5A.
REQ-021 SHALL implement states IDLE, SEND_TOKEN, SEND_DATA, WAIT_HS, WAIT_DATA, SEND_HS and DONE.
REQ-022 SHALL assert ptcl_ready = (state == IDLE), combinationally.
REQ-023 SHALL, in IDLE with data_avail=1, latch token_pkt and data_pkt, clear the attempt counter, and go to SEND_TOKEN on the next edge.
REQ-024 SHALL pulse tx_start in the first cycle of each SEND_* state and hold tx_pkt/tx_kind stable until tx_done.
REQ-025 SHALL, in SEND_TOKEN on tx_done, go to SEND_DATA if the latched PID is OUT, to WAIT_DATA if it is IN, and to DONE with failure for any other PID.
REQ-026 SHALL, in SEND_DATA on tx_done, go to WAIT_HS and clear the timer.
REQ-027 SHALL, in WAIT_HS:
- rx_valid with ACK and rx_crc_ok -> DONE success;
- NAK, bad CRC, any other PID, or timeout -> retry.
REQ-028 SHALL, in WAIT_DATA:
- rx_valid with DATA0 and rx_crc_ok -> latch rx_payload into rx_data, then SEND_HS with ACK;
- rx_valid with bad CRC or a wrong PID -> SEND_HS with NAK, then retry after its tx_done;
- timeout -> retry directly.
REQ-029 SHALL, in SEND_HS (ACK) on tx_done, go to DONE success.
REQ-030 SHALL implement retry as: increment attempts; if attempts == MAX_TRIES, go to DONE failure; otherwise go to SEND_TOKEN, resending the token and then the data for OUT.
REQ-031 SHALL use a timer that counts cycles in WAIT_* states, with timeout asserted in the cycle where the count reaches TIMEOUT-1.
REQ-032 SHALL give rx_valid priority over timeout when both occur in the same cycle.
REQ-033 SHALL ignore rx_valid outside WAIT_* states and tx_done outside SEND_* states.
REQ-034 SHALL stay in DONE exactly one cycle, with ptcl_done=1 and ptcl_success set, then go to IDLE; data_avail is not sampled in DONE.
REQ-035 SHALL hold rx_data until the next successful IN transaction.

Reset
REQ-036 SHALL, on rst_b low, asynchronously force state IDLE, attempts 0, timer 0, tx_start 0, tx_kind 0, tx_pkt 0, ptcl_done 0, ptcl_success 0, rx_data 0, and ptcl_ready 1.
REQ-037 SHALL, on reset in the middle of a transaction, abandon it with no ptcl_done pulse.

Verification
REQ-038 SHALL be verified by: OUT token 19'h70A02 plus data, with ACK returned -> tx token, then data, then ptcl_done=1 with ptcl_success=1.
REQ-039 SHALL be verified by: IN token plus DATA0 payload 64'hDEADBEEF01234567 with CRC good -> ACK sent, rx_data equals the payload, ptcl_success=1.
REQ-040 SHALL be verified by: OUT with NAK three times, then ACK -> four token sends, success.
REQ-041 SHALL be verified by: IN with no response ever -> 8 token sends 256 cycles apart, then ptcl_done=1 with ptcl_success=0.
REQ-042 SHALL be verified by: rx_valid with ACK in the same cycle as timeout -> success, with no retry.
REQ-043 SHALL be verified by: rst_b low during WAIT_HS -> IDLE, ptcl_ready=1, and no ptcl_done pulse.

Source files
------------

// File: rtl/protocol_fsm.sv
`default_nettype none
// ============================================================================
// Module   : protocol_fsm
// Purpose  : Transaction-level protocol engine. Sends a token, then a data
//            packet (OUT) or waits for a data packet (IN), collects or sends
//            the handshake, and retries on NAK, bad CRC, wrong PID or
//            response timeout, up to MAX_TRIES attempts.
// Ports    : clk, rst_b        - clock, asynchronous active-low reset
//            token_pkt         - {PID, ADDR, ENDP} of the requested transaction
//            data_pkt          - {PID, payload} sent for OUT transactions
//            data_avail        - upstream request, sampled only while idle
//            ptcl_ready        - idle and able to accept a request
//            ptcl_done         - one-cycle end-of-transaction pulse
//            ptcl_success      - transaction result, valid with ptcl_done
//            rx_data           - payload of the last successful IN transaction
//            tx_start/kind/pkt - packet request to the bit encoder
//            tx_done           - encoder finished the packet and EOP
//            rx_valid/pid/payload/crc_ok - decoded received packet
// Revision : 1.0 - initial release
// ============================================================================
module protocol_fsm #(
  parameter int TIMEOUT   = 256,
  parameter int MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [18:0] token_pkt,
  input  logic [71:0] data_pkt,
  input  logic        data_avail,
  output logic        ptcl_ready,
  output logic        ptcl_done,
  output logic        ptcl_success,
  output logic [63:0] rx_data,
  output logic        tx_start,
  output logic [1:0]  tx_kind,
  output logic [71:0] tx_pkt,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [7:0]  rx_pid,
  input  logic [63:0] rx_payload,
  input  logic        rx_crc_ok
);

  localparam logic [7:0] c_pid_out   = 8'hE1;
  localparam logic [7:0] c_pid_in    = 8'h69;
  localparam logic [7:0] c_pid_data0 = 8'hC3;
  localparam logic [7:0] c_pid_ack   = 8'hD2;
  localparam logic [7:0] c_pid_nak   = 8'h5A;

  localparam logic [1:0] c_kind_token = 2'b00;
  localparam logic [1:0] c_kind_data  = 2'b01;
  localparam logic [1:0] c_kind_hs    = 2'b10;

  localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_aw = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_TOKEN = 3'd1,
    SEND_DATA  = 3'd2,
    WAIT_HS    = 3'd3,
    WAIT_DATA  = 3'd4,
    SEND_HS    = 3'd5,
    DONE       = 3'd6
  } state_e;

  state_e            state_q,    state_d;
  logic [18:0]       token_q,    token_d;
  logic [71:0]       data_q,     data_d;
  logic [c_aw-1:0]   attempts_q, attempts_d;
  logic [c_tw-1:0]   timer_q,    timer_d;
  logic              hs_ack_q,   hs_ack_d;   // handshake to send: 1 ACK, 0 NAK
  logic              success_q,  success_d;
  logic [63:0]       rx_data_q,  rx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        tx_kind_q,  tx_kind_d;
  logic [71:0]       tx_pkt_q,   tx_pkt_d;

  logic              timeout;
  logic              retry;

  assign timeout = (timer_q == c_tw'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    token_d    = token_q;
    data_d     = data_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    hs_ack_d   = hs_ack_q;
    success_d  = success_q;
    rx_data_d  = rx_data_q;
    retry      = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_avail) begin
          token_d    = token_pkt;
          data_d     = data_pkt;
          attempts_d = '0;
          state_d    = SEND_TOKEN;
        end
      end
      SEND_TOKEN: begin
        if (tx_done) begin
          if (token_q[18:11] == c_pid_out) begin
            state_d = SEND_DATA;
          end else if (token_q[18:11] == c_pid_in) begin
            state_d = WAIT_DATA;
            timer_d = '0;
          end else begin
            state_d   = DONE;
            success_d = 1'b0;
          end
        end
      end
      SEND_DATA: begin
        if (tx_done) begin
          state_d = WAIT_HS;
          timer_d = '0;
        end
      end
      WAIT_HS: begin
        timer_d = timer_q + 1'b1;
        // A decoded packet wins over a timeout landing in the same cycle.
        if (rx_valid) begin
          if (rx_pid == c_pid_ack && rx_crc_ok) begin
            state_d   = DONE;
            success_d = 1'b1;
          end else begin
            retry = 1'b1;
          end
        end else if (timeout) begin
          retry = 1'b1;
        end
      end
      WAIT_DATA: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          state_d = SEND_HS;
          if (rx_pid == c_pid_data0 && rx_crc_ok) begin
            rx_data_d = rx_payload;
            hs_ack_d  = 1'b1;
          end else begin
            hs_ack_d  = 1'b0;
          end
        end else if (timeout) begin
          retry = 1'b1;
        end
      end
      SEND_HS: begin
        if (tx_done) begin
          if (hs_ack_q) begin
            state_d   = DONE;
            success_d = 1'b1;
          end else begin
            retry = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (retry) begin
      attempts_d = attempts_q + 1'b1;
      if (attempts_d == c_aw'(MAX_TRIES)) begin
        state_d   = DONE;
        success_d = 1'b0;
      end else begin
        state_d = SEND_TOKEN;
      end
    end

    // Encoder request is registered on entry to a SEND_* state so tx_start is
    // a single pulse and tx_kind/tx_pkt hold their value for the whole send.
    tx_start_d = 1'b0;
    tx_kind_d  = tx_kind_q;
    tx_pkt_d   = tx_pkt_q;
    if (state_d != state_q) begin
      case (state_d)
        SEND_TOKEN: begin
          tx_start_d = 1'b1;
          tx_kind_d  = c_kind_token;
          tx_pkt_d   = {53'd0, token_d};
        end
        SEND_DATA: begin
          tx_start_d = 1'b1;
          tx_kind_d  = c_kind_data;
          tx_pkt_d   = data_q;
        end
        SEND_HS: begin
          tx_start_d = 1'b1;
          tx_kind_d  = c_kind_hs;
          tx_pkt_d   = {64'd0, (hs_ack_d ? c_pid_ack : c_pid_nak)};
        end
        default: begin
          tx_start_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      token_q    <= '0;
      data_q     <= '0;
      attempts_q <= '0;
      timer_q    <= '0;
      hs_ack_q   <= 1'b0;
      success_q  <= 1'b0;
      rx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_kind_q  <= '0;
      tx_pkt_q   <= '0;
    end else begin
      state_q    <= state_d;
      token_q    <= token_d;
      data_q     <= data_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
      hs_ack_q   <= hs_ack_d;
      success_q  <= success_d;
      rx_data_q  <= rx_data_d;
      tx_start_q <= tx_start_d;
      tx_kind_q  <= tx_kind_d;
      tx_pkt_q   <= tx_pkt_d;
    end
  end

  assign ptcl_ready   = (state_q == IDLE);
  assign ptcl_done    = (state_q == DONE);
  assign ptcl_success = (state_q == DONE) && success_q;
  assign rx_data      = rx_data_q;
  assign tx_start     = tx_start_q;
  assign tx_kind      = tx_kind_q;
  assign tx_pkt       = tx_pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_protocol_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_protocol_fsm
// Purpose  : Self-checking bench for protocol_fsm. Emulates the bit encoder
//            and the far-end responder, and compares the packet stream and
//            outcome of each transaction with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_protocol_fsm;

  localparam int TIMEOUT   = 256;
  localparam int MAX_TRIES = 8;
  localparam logic [7:0] PID_OUT = 8'hE1, PID_IN = 8'h69, PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK = 8'hD2, PID_NAK = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [18:0] token_pkt = '0;
  logic [71:0] data_pkt = '0;
  logic        data_avail = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_pid = '0;
  logic [63:0] rx_payload = '0;
  logic        rx_crc_ok = 1'b0;
  logic        ptcl_ready, ptcl_done, ptcl_success, tx_start;
  logic [63:0] rx_data;
  logic [1:0]  tx_kind;
  logic [71:0] tx_pkt;

  always #5 clk = ~clk;

  protocol_fsm #(.TIMEOUT(TIMEOUT), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst_b(rst_b), .token_pkt(token_pkt), .data_pkt(data_pkt),
    .data_avail(data_avail), .ptcl_ready(ptcl_ready), .ptcl_done(ptcl_done),
    .ptcl_success(ptcl_success), .rx_data(rx_data), .tx_start(tx_start),
    .tx_kind(tx_kind), .tx_pkt(tx_pkt), .tx_done(tx_done), .rx_valid(rx_valid),
    .rx_pid(rx_pid), .rx_payload(rx_payload), .rx_crc_ok(rx_crc_ok)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario: token/data plus the far end's reply to each attempt.
  // r_has=0 means no reply before the timeout.
  logic [18:0] sc_token;
  logic [71:0] sc_data;
  bit          r_has [MAX_TRIES];
  logic [7:0]  r_pid [MAX_TRIES];
  bit          r_crc [MAX_TRIES];
  int          r_dly [MAX_TRIES];
  logic [63:0] r_pay [MAX_TRIES];
  int          enc_lat;
  bit          noise_en;

  // Model results
  logic [1:0]  exp_kind[$];
  logic [71:0] exp_pkt[$];
  bit          exp_success;
  logic [63:0] model_rx = '0;

  // Observations
  logic [1:0]  obs_kind[$];
  logic [71:0] obs_pkt[$];
  int          obs_cyc[$];
  int          obs_unstable, obs_done_cnt, obs_stray;
  bit          obs_success, obs_ready_after;
  logic [63:0] obs_rx;

  task automatic clear_scenario(input logic [18:0] tok, input int lat, input bit noise);
    sc_token = tok;
    sc_data  = {PID_DATA0, 32'($urandom), 32'($urandom)};
    enc_lat  = lat;
    noise_en = noise;
    for (int a = 0; a < MAX_TRIES; a++) begin
      r_has[a] = 1'b0; r_pid[a] = '0; r_crc[a] = 1'b0; r_dly[a] = 0;
      r_pay[a] = {$urandom, $urandom};
    end
  endtask

  // Transaction-level model: each attempt is one token, then the data (OUT)
  // or the reply handling (IN); the transaction ends on success, on an
  // unknown token PID, or after MAX_TRIES attempts.
  function automatic void build_expected();
    logic [7:0] pid;
    pid = sc_token[18:11];
    exp_kind.delete(); exp_pkt.delete(); exp_success = 1'b0;
    for (int a = 0; a < MAX_TRIES; a++) begin
      exp_kind.push_back(2'b00); exp_pkt.push_back({53'd0, sc_token});
      if (pid == PID_OUT) begin
        exp_kind.push_back(2'b01); exp_pkt.push_back(sc_data);
        if (r_has[a] && r_pid[a] == PID_ACK && r_crc[a]) begin exp_success = 1'b1; return; end
      end else if (pid == PID_IN) begin
        if (r_has[a]) begin
          exp_kind.push_back(2'b10);
          if (r_pid[a] == PID_DATA0 && r_crc[a]) begin
            exp_pkt.push_back({64'd0, PID_ACK}); exp_success = 1'b1; model_rx = r_pay[a];
            return;
          end
          exp_pkt.push_back({64'd0, PID_NAK});
        end
      end else begin
        return;
      end
    end
  endfunction

  // Drives one transaction, playing encoder and responder, and records what
  // the DUT sends. Inputs change at negedge; outputs are sampled there too.
  task automatic run_txn(input int max_cycles);
    int enc_left, rk, ai, cyc;
    bit arm, wait_next;
    logic [1:0]  cur_kind;
    logic [71:0] cur_pkt;
    enc_left = 0; rk = 0; ai = 0; cyc = 0; arm = 0; wait_next = 0;
    cur_kind = '0; cur_pkt = '0;
    obs_kind.delete(); obs_pkt.delete(); obs_cyc.delete();
    obs_unstable = 0; obs_done_cnt = 0; obs_stray = 0; obs_success = 0; obs_ready_after = 0;
    obs_rx = rx_data;
    @(negedge clk);
    token_pkt = sc_token; data_pkt = sc_data; data_avail = 1'b1;
    while (cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      data_avail = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
      rx_pid = 8'($urandom); rx_crc_ok = 1'($urandom); rx_payload = {$urandom, $urandom};
      token_pkt = 19'($urandom); data_pkt = {8'($urandom), $urandom, $urandom};
      if (ptcl_done === 1'b1) begin
        obs_done_cnt++; obs_success = ptcl_success;
        // A request offered during DONE must not be taken.
        data_avail = 1'b1; token_pkt = {PID_IN, 11'h0AB};
        @(negedge clk);
        data_avail = 1'b0; obs_ready_after = ptcl_ready;
        repeat (4) begin
          @(negedge clk);
          if (tx_start !== 1'b0 || ptcl_done !== 1'b0 || ptcl_ready !== 1'b1) obs_stray++;
        end
        obs_rx = rx_data;
        return;
      end
      if (arm) begin
        rk++;
        if (rk == r_dly[ai]) begin
          rx_valid = 1'b1; rx_pid = r_pid[ai]; rx_crc_ok = r_crc[ai]; rx_payload = r_pay[ai];
          arm = 1'b0;
        end
      end
      if (enc_left > 0) begin
        if (tx_kind !== cur_kind || tx_pkt !== cur_pkt) obs_unstable++;
        enc_left--;
        if (enc_left == 0) begin
          tx_done = 1'b1;
          if (wait_next && r_has[ai]) begin arm = 1'b1; rk = -1; end
        end
      end
      if (tx_start === 1'b1) begin
        if (tx_kind == 2'b00 && obs_kind.size() > 0 && ai < MAX_TRIES - 1) ai++;
        cur_kind = tx_kind; cur_pkt = tx_pkt;
        obs_kind.push_back(tx_kind); obs_pkt.push_back(tx_pkt); obs_cyc.push_back(cyc);
        enc_left = enc_lat; arm = 1'b0;
        wait_next = (tx_kind == 2'b01) || (tx_kind == 2'b00 && sc_token[18:11] == PID_IN);
      end
      // Stray pulses the DUT must ignore: rx_valid while sending, tx_done while waiting.
      if (noise_en && !rx_valid && (enc_left > 0 || tx_done) && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1; rx_pid = PID_ACK; rx_crc_ok = 1'b1;
      end
      if (noise_en && arm && !tx_done && $urandom_range(0, 7) == 0) tx_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ptcl_ready !== 1'b1) begin n_fail++; $display("FAIL reset ptcl_ready: got %b expected 1", ptcl_ready); end
    n_checks++; if (ptcl_done !== 1'b0) begin n_fail++; $display("FAIL reset ptcl_done: got %b expected 0", ptcl_done); end
    n_checks++; if (ptcl_success !== 1'b0) begin n_fail++; $display("FAIL reset ptcl_success: got %b expected 0", ptcl_success); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset tx_start: got %b expected 0", tx_start); end
    n_checks++; if (tx_kind !== 2'b00) begin n_fail++; $display("FAIL reset tx_kind: got %b expected 00", tx_kind); end
    n_checks++; if (tx_pkt !== 72'd0) begin n_fail++; $display("FAIL reset tx_pkt: got %h expected 0", tx_pkt); end
    n_checks++; if (rx_data !== 64'd0) begin n_fail++; $display("FAIL reset rx_data: got %h expected 0", rx_data); end
    rst_b = 1'b1;
    model_rx = '0;
    @(negedge clk);
  endtask

  task automatic test_out_ack();
    int bad;
    clear_scenario(19'h70A02, $urandom_range(1, 4), 1'b1);
    r_has[0] = 1'b1; r_pid[0] = PID_ACK; r_crc[0] = 1'b1; r_dly[0] = $urandom_range(0, 30);
    build_expected();
    run_txn(2000);
    bad = 0;
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++)
      if (obs_kind[i] !== exp_kind[i] || obs_pkt[i] !== exp_pkt[i]) bad++;
    n_checks++; if (obs_kind.size() != 2) begin n_fail++; $display("FAIL out_ack pkt_count: got %0d expected 2", obs_kind.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL out_ack pkt_seq: %0d packets differ, expected 0", bad); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL out_ack done_count: got %0d expected 1", obs_done_cnt); end
    n_checks++; if (obs_success !== 1'b1) begin n_fail++; $display("FAIL out_ack success: got %b expected 1", obs_success); end
    n_checks++; if (obs_unstable != 0) begin n_fail++; $display("FAIL out_ack tx_stable: got %0d changes expected 0", obs_unstable); end
    n_checks++; if (obs_ready_after !== 1'b1 || obs_stray != 0) begin n_fail++; $display("FAIL out_ack done_to_idle: ready %b stray %0d expected 1/0", obs_ready_after, obs_stray); end
  endtask

  task automatic test_in_data();
    int bad;
    clear_scenario({PID_IN, 7'h15, 4'h3}, $urandom_range(1, 4), 1'b1);
    r_has[0] = 1'b1; r_pid[0] = PID_DATA0; r_crc[0] = 1'b1; r_dly[0] = $urandom_range(0, 30);
    r_pay[0] = 64'hDEADBEEF01234567;
    build_expected();
    run_txn(2000);
    bad = 0;
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++)
      if (obs_kind[i] !== exp_kind[i] || obs_pkt[i] !== exp_pkt[i]) bad++;
    n_checks++; if (obs_kind.size() != 2) begin n_fail++; $display("FAIL in_data pkt_count: got %0d expected 2", obs_kind.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL in_data pkt_seq: %0d packets differ, expected 0", bad); end
    n_checks++; if (obs_success !== 1'b1 || obs_done_cnt != 1) begin n_fail++; $display("FAIL in_data success: got %b/%0d expected 1/1", obs_success, obs_done_cnt); end
    n_checks++; if (obs_rx !== 64'hDEADBEEF01234567) begin n_fail++; $display("FAIL in_data rx_data: got %h expected deadbeef01234567", obs_rx); end
  endtask

  task automatic test_out_nak_retry();
    int bad, ntok;
    clear_scenario({PID_OUT, 7'h2A, 4'h1}, $urandom_range(1, 4), 1'b1);
    for (int a = 0; a < 4; a++) begin
      r_has[a] = 1'b1; r_crc[a] = 1'b1; r_dly[a] = $urandom_range(0, 20);
      r_pid[a] = (a < 3) ? PID_NAK : PID_ACK;
    end
    build_expected();
    run_txn(3000);
    bad = 0; ntok = 0;
    for (int i = 0; i < obs_kind.size(); i++) if (obs_kind[i] == 2'b00) ntok++;
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++)
      if (obs_kind[i] !== exp_kind[i] || obs_pkt[i] !== exp_pkt[i]) bad++;
    n_checks++; if (ntok != 4) begin n_fail++; $display("FAIL nak_retry token_sends: got %0d expected 4", ntok); end
    n_checks++; if (bad != 0 || obs_kind.size() != exp_kind.size()) begin n_fail++; $display("FAIL nak_retry pkt_seq: %0d differ, %0d sent, expected 0, %0d", bad, obs_kind.size(), exp_kind.size()); end
    n_checks++; if (obs_success !== 1'b1 || obs_done_cnt != 1) begin n_fail++; $display("FAIL nak_retry success: got %b/%0d expected 1/1", obs_success, obs_done_cnt); end
  endtask

  task automatic test_in_timeout();
    int bad, ntok;
    clear_scenario({PID_IN, 7'h05, 4'h0}, 2, 1'b1);
    build_expected();
    run_txn(4000);
    bad = 0; ntok = 0;
    for (int i = 0; i < obs_kind.size(); i++) if (obs_kind[i] == 2'b00) ntok++;
    // Token send spans enc_lat+1 cycles, followed by TIMEOUT waiting cycles.
    for (int i = 1; i < obs_cyc.size(); i++)
      if (obs_cyc[i] - obs_cyc[i-1] != TIMEOUT + enc_lat + 1) bad++;
    n_checks++; if (ntok != MAX_TRIES || obs_kind.size() != MAX_TRIES) begin n_fail++; $display("FAIL in_timeout token_sends: got %0d of %0d expected %0d", ntok, obs_kind.size(), MAX_TRIES); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL in_timeout spacing: %0d gaps wrong, expected 0 (gap %0d)", bad, TIMEOUT + enc_lat + 1); end
    n_checks++; if (obs_done_cnt != 1 || obs_success !== 1'b0) begin n_fail++; $display("FAIL in_timeout result: done %0d success %b expected 1/0", obs_done_cnt, obs_success); end
  endtask

  task automatic test_ack_at_timeout();
    int ntok;
    clear_scenario({PID_OUT, 7'h7F, 4'hF}, 2, 1'b0);
    r_has[0] = 1'b1; r_pid[0] = PID_ACK; r_crc[0] = 1'b1; r_dly[0] = TIMEOUT - 1;
    build_expected();
    run_txn(2000);
    ntok = 0;
    for (int i = 0; i < obs_kind.size(); i++) if (obs_kind[i] == 2'b00) ntok++;
    n_checks++; if (ntok != 1) begin n_fail++; $display("FAIL ack_at_timeout token_sends: got %0d expected 1", ntok); end
    n_checks++; if (obs_done_cnt != 1 || obs_success !== 1'b1) begin n_fail++; $display("FAIL ack_at_timeout result: done %0d success %b expected 1/1", obs_done_cnt, obs_success); end
  endtask

  task automatic test_random();
    logic [7:0] pids [5];
    logic [7:0] rsp  [4];
    pids = '{PID_OUT, PID_IN, PID_OUT, PID_IN, 8'h2D};
    for (int it = 0; it < 12; it++) begin
      int bad;
      clear_scenario({pids[$urandom_range(0, 4)], 11'($urandom)}, $urandom_range(1, 4), 1'b1);
      rsp = '{PID_ACK, PID_NAK, PID_DATA0, 8'($urandom)};
      for (int a = 0; a < MAX_TRIES; a++) begin
        r_has[a] = ($urandom_range(0, 7) != 0);
        r_pid[a] = rsp[$urandom_range(0, 3)];
        r_crc[a] = ($urandom_range(0, 3) != 0);
        r_dly[a] = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 30);
      end
      build_expected();
      run_txn(4000);
      bad = 0;
      for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++)
        if (obs_kind[i] !== exp_kind[i] || obs_pkt[i] !== exp_pkt[i]) bad++;
      n_checks++; if (bad != 0 || obs_kind.size() != exp_kind.size()) begin n_fail++; $display("FAIL random[%0d] pkt_seq: %0d differ, %0d sent, expected 0, %0d", it, bad, obs_kind.size(), exp_kind.size()); end
      n_checks++; if (obs_done_cnt != 1 || obs_success !== exp_success) begin n_fail++; $display("FAIL random[%0d] result: done %0d success %b expected 1/%b", it, obs_done_cnt, obs_success, exp_success); end
      n_checks++; if (obs_rx !== model_rx) begin n_fail++; $display("FAIL random[%0d] rx_data: got %h expected %h", it, obs_rx, model_rx); end
      n_checks++; if (obs_unstable != 0 || obs_stray != 0 || obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL random[%0d] handshake: unstable %0d stray %0d ready %b expected 0/0/1", it, obs_unstable, obs_stray, obs_ready_after); end
    end
  endtask

  task automatic test_reset_mid_txn();
    bit seen;
    int ndone, nbusy;
    @(negedge clk);
    token_pkt = 19'h70A02; data_pkt = {PID_DATA0, 64'h1122334455667788}; data_avail = 1'b1;
    @(negedge clk);
    data_avail = 1'b0;
    for (int p = 0; p < 2; p++) begin
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        if (tx_start === 1'b1) seen = 1'b1; else @(negedge clk);
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid tx_start[%0d]: got none expected pulse", p); end
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
    end
    repeat (5) @(negedge clk);
    n_checks++; if (ptcl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: ptcl_ready got %b expected 0", ptcl_ready); end
    #2 rst_b = 1'b0;
    #1;
    n_checks++; if (ptcl_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid async_ready: got %b expected 1", ptcl_ready); end
    n_checks++; if (tx_kind !== 2'b00 || tx_pkt !== 72'd0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid tx_clear: kind %b pkt %h start %b expected 0", tx_kind, tx_pkt, tx_start); end
    n_checks++; if (rx_data !== 64'd0) begin n_fail++; $display("FAIL reset_mid rx_data: got %h expected 0", rx_data); end
    @(negedge clk);
    rst_b = 1'b1;
    model_rx = '0;
    ndone = 0; nbusy = 0;
    repeat (TIMEOUT + 40) begin
      @(negedge clk);
      if (ptcl_done !== 1'b0) ndone++;
      if (ptcl_ready !== 1'b1) nbusy++;
    end
    n_checks++; if (ndone != 0 || nbusy != 0) begin n_fail++; $display("FAIL reset_mid abandon: done pulses %0d busy cycles %0d expected 0/0", ndone, nbusy); end
  endtask

  initial begin
    test_reset();
    test_out_ack();
    test_in_data();
    test_out_nak_retry();
    test_in_timeout();
    test_ack_at_timeout();
    test_random();
    test_reset_mid_txn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
